dma_bus_controller: RTL and testbench
=====================================

Name: dma_bus_controller

Overview:
- Sequences DMA block transfers from an external device buffer into D-memory.
- Owns the bus-request/grant handshake with the CPU-side D-cache.
- While BG is high, the D-cache parks its memory port at high impedance and this block drives the D-memory bus in 64-bit (4-word) bursts.
- It publishes dma_state, a progress count the D-cache watches to leave its INTERRUPT state, and raises a completion interrupt.

Parameters:
- WORD_SIZE, 16, address/word width.
- FETCH_SIZE, 64, burst data width (4 words).
- BURST_NUM, 3, 64-bit bursts per transfer (12 words).
- MEM_LAT, 4, cycles per D-memory write burst.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  CPU pulse: start transfer.
- cmd_addr  input  WORD_SIZE  D-memory destination base address, must be 4-word aligned.
- cmd_ready  output  1  controller idle, accepts cmd_valid.
- BR  output  1  bus request to CPU/D-cache.
- BG  input  1  bus grant from CPU.
- dev_data  input  FETCH_SIZE  device buffer, current burst.
- dev_idx  output  2  burst index presented to device.
- d_writeM  output  1  D-memory write strobe; z when not granted.
- d_addressM  output  WORD_SIZE  D-memory address; z when not granted.
- d_dataM  output  FETCH_SIZE  D-memory write data; z when not granted.
- dma_state  output  4  transfer progress count.
- dma_done  output  1  one-cycle completion interrupt.

Behaviour:
Reset values:
- cmd_ready=1, BR=0, dev_idx=0, dma_state=0, dma_done=0.
- d_writeM, d_addressM and d_dataM are all z.
- State is IDLE.

Reset asserted mid-transfer:
- Aborts immediately to these values.
- No partial-burst completion.
- Memory contents are undefined for the interrupted burst.

State machine (IDLE, REQ, XFER, NEXT, DONE):
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr into base, clear burst counter b and dma_state, then go to REQ.
  - cmd_valid outside IDLE is ignored (cmd_ready=0).
- REQ: BR=1. Wait for BG=1, then go to XFER. No timeout.
- XFER: BR=1, bus driven.
  - d_addressM = base + 4*b (modulo 2^WORD_SIZE, wraps silently).
  - d_dataM = dev_data, and dev_idx = b.
  - d_writeM=1 in the first cycle of the burst only; 0 for the remaining MEM_LAT-1 cycles.
  - dma_state increments by 1 each XFER cycle, starting from 0.
  - After MEM_LAT cycles: go to NEXT if b < BURST_NUM-1, else DONE.
- NEXT: b <= b+1, then back to XFER.
  - No gap cycle is added to dma_state; dma_state holds its value during NEXT.
- DONE: BR=0 and bus outputs return to z in the same cycle. dma_done=1 for exactly one cycle, then go to IDLE.

dma_state rules:
- Saturates at BURST_NUM*MEM_LAT-1 (11 with defaults).
- Holds that value through DONE; cleared on the next accepted command.
- The D-cache releases from INTERRUPT when it sees 11.

Bus ownership and BG protocol:
- The bus is driven only in XFER/NEXT with BG=1.
- If BG drops during XFER/NEXT (protocol violation): tri-state the bus that cycle, return to REQ, and restart the current burst b. dma_state rewinds to b*MEM_LAT.
- BG asserted while BR=0 is ignored.

Simultaneous cmd_valid and reset: reset wins.

Optional Feature:
- Macro DMA_CYCLE_STEAL_EN.
- Defined: after each non-final burst, the block drops BR for one cycle (state RELEASE in place of NEXT), then re-enters REQ and must regain BG before the next burst. This lets pending I/D-cache misses use the bus between bursts. dma_state holds through RELEASE/REQ.
- Undefined: the bus is held continuously for the whole transfer, as described above.

Decomposition:
- Shared package/header (alongside the opcode definitions):
  - state encodings IDLE..DONE and RELEASE;
  - DMA_LAST_STATE = 4'd11;
  - WORD_SIZE and FETCH_SIZE defines (reuse existing).
- One natural sub-module, dma_burst_timer: MEM_LAT-cycle down-counter with start/expire, reused per burst.

Test Plan:
- Basic transfer: after reset, cmd_valid with cmd_addr=16'h01F0; BG returned 2 cycles after BR.
  - Three write strobes at addresses 01F0, 01F4, 01F8, 4 cycles apart.
  - dma_state counts 0..11.
  - dma_done pulses once; BR=0 in the DONE cycle.
- Grant latency: BG held low 20 cycles.
  - BR stays 1 and the bus stays z throughout.
  - The first write occurs in the first cycle with BG=1.
- BG drop mid-burst: BG deasserted during burst 1, cycle 2.
  - Bus goes z that cycle; dma_state rewinds to 4.
  - After re-grant, burst 1 is rewritten at base+4.
- Address wrap: cmd_addr=16'hFFF8.
  - Bursts at FFF8, FFFC, 0000.
- Async reset mid-XFER: reset_n low for 1 cycle during burst 2.
  - All outputs return to reset values immediately; cmd_ready=1.
- DMA_CYCLE_STEAL_EN build: BR observed low for exactly one cycle after bursts 0 and 1.
  - Writes occur only after BG is regained.
  - dma_state is not incremented during the gaps.

Source files
------------

// File: rtl/dma_bus_controller_pkg.sv
// Shared definitions for the DMA bus controller.
//   - bus/word geometry (WORD_SIZE, FETCH_SIZE, BURST_NUM, MEM_LAT)
//   - controller state encoding, including RELEASE, which is used only when
//     DMA_CYCLE_STEAL_EN is defined
//   - DMA_LAST_STATE: final dma_state value that the D-cache waits for
package dma_bus_controller_pkg;

   localparam int unsigned WORD_SIZE       = 16;
   localparam int unsigned FETCH_SIZE      = 64;
   localparam int unsigned BURST_NUM       = 3;
   localparam int unsigned MEM_LAT         = 4;
   localparam int unsigned WORDS_PER_BURST = FETCH_SIZE / WORD_SIZE;

   localparam logic [3:0] DMA_LAST_STATE = 4'd11;
   localparam logic [1:0] LAST_BURST     = 2'(BURST_NUM - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_XFER,
      ST_NEXT,
      ST_DONE,
      ST_RELEASE
   } dma_fsm_e;

   // dma_state value at the start of burst b (used for BG-drop rewind)
   function automatic logic [3:0] burst_start(input logic [1:0] b);
      return 4'(b) * 4'(MEM_LAT);
   endfunction

endpackage

// File: rtl/dma_bus_controller_burst_timer.sv
// dma_burst_timer: MEM_LAT-cycle down-counter, reloaded for every burst.
//   clk, reset_n : clock, async active-low reset
//   start        : load MEM_LAT-1 (asserted the cycle before a burst begins)
//   run          : count down one step (asserted on each owned burst cycle)
//   first        : counter is at its load value (first cycle of the burst)
//   expire       : counter is at zero (last cycle of the burst)
module dma_burst_timer
   import dma_bus_controller_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic run,
   output logic first,
   output logic expire
);

   localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (start) begin
         count <= CW'(MEM_LAT - 1);
      end else if (run && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign first  = (count == CW'(MEM_LAT - 1));
   assign expire = (count == '0);

endmodule

// File: rtl/dma_bus_controller.sv
// dma_bus_controller: moves BURST_NUM 64-bit bursts from a device buffer into
// D-memory, owning the BR/BG handshake with the D-cache.
//   cmd_valid/cmd_addr/cmd_ready : start command (accepted only when idle)
//   BR / BG                      : bus request out, bus grant in
//   dev_data / dev_idx           : device burst data and its burst index
//   d_writeM/d_addressM/d_dataM  : D-memory port, high impedance unless granted
//   dma_state                    : progress count, saturates at DMA_LAST_STATE
//   dma_done                     : one-cycle completion interrupt
// Build option DMA_CYCLE_STEAL_EN: release the bus for one cycle between bursts.
module dma_bus_controller
   import dma_bus_controller_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   input  logic [WORD_SIZE-1:0]  cmd_addr,
   output logic                  cmd_ready,
   output logic                  BR,
   input  logic                  BG,
   input  logic [FETCH_SIZE-1:0] dev_data,
   output logic [1:0]            dev_idx,
   output logic                  d_writeM,
   output logic [WORD_SIZE-1:0]  d_addressM,
   output logic [FETCH_SIZE-1:0] d_dataM,
   output logic [3:0]            dma_state,
   output logic                  dma_done
);

   dma_fsm_e             state, state_next;
   logic [WORD_SIZE-1:0] base;
   logic [1:0]           burst;
   logic [3:0]           progress;
   logic                 drive, strobe, start, run, first, expire;

   dma_burst_timer u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .run     (run),
      .first   (first),
      .expire  (expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:    if (cmd_valid) state_next = ST_REQ;
         ST_REQ:     if (BG) state_next = ST_XFER;
         ST_XFER: begin
            if (!BG) begin
               state_next = ST_REQ;
            end else if (expire) begin
               if (burst == LAST_BURST) state_next = ST_DONE;
`ifdef DMA_CYCLE_STEAL_EN
               else                     state_next = ST_RELEASE;
`else
               else                     state_next = ST_NEXT;
`endif
            end
         end
         ST_NEXT:    state_next = BG ? ST_XFER : ST_REQ;
         ST_RELEASE: state_next = ST_REQ;
         ST_DONE:    state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Losing BG in XFER or NEXT restarts the current burst, so progress is
   // rewound to that burst's first count and burst is left unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base     <= '0;
         burst    <= '0;
         progress <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  base     <= cmd_addr;
                  burst    <= '0;
                  progress <= '0;
               end
            end
            ST_XFER: begin
               if (!BG)                               progress <= burst_start(burst);
               else if (progress != DMA_LAST_STATE)   progress <= progress + 1'b1;
            end
            ST_NEXT: begin
               if (!BG) progress <= burst_start(burst);
               else     burst    <= burst + 1'b1;
            end
            ST_RELEASE: burst <= burst + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      cmd_ready = (state == ST_IDLE);
      BR        = (state == ST_REQ) || (state == ST_XFER) || (state == ST_NEXT);
      drive     = ((state == ST_XFER) || (state == ST_NEXT)) && BG;
      strobe    = (state == ST_XFER) && first;
      start     = BG && ((state == ST_REQ) || (state == ST_NEXT));
      run       = (state == ST_XFER) && BG;
      dma_done  = (state == ST_DONE);
   end

   assign dev_idx    = burst;
   assign dma_state  = progress;
   assign d_writeM   = drive ? strobe : 1'bz;
   assign d_addressM = drive ? base + WORD_SIZE'(burst) * WORD_SIZE'(WORDS_PER_BURST) : 'z;
   assign d_dataM    = drive ? dev_data : 'z;

endmodule

// File: tb/tb_dma_bus_controller.sv
// Bench for dma_bus_controller. A transaction-level model tracks the transfer
// as a slot count within each burst window and predicts every output each
// cycle; a write scoreboard checks the order of burst addresses per transfer.
// The D-memory address bus is pulled up and the write strobe pulled down, so
// a released bus reads as all-ones address with no strobe.
module tb_dma_bus_controller;
   import dma_bus_controller_pkg::*;

`ifdef DMA_CYCLE_STEAL_EN
   localparam bit STEAL = 1'b1;
   localparam int DROP_C_MAX = MEM_LAT - 1;
`else
   localparam bit STEAL = 1'b0;
   localparam int DROP_C_MAX = MEM_LAT;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic cmd_valid = 1'b0;
   logic BG = 1'b0;
   logic [WORD_SIZE-1:0]  cmd_addr = '0;
   logic [FETCH_SIZE-1:0] dev_data;
   logic [63:0]           salt = 64'h0;
   logic cmd_ready, BR, dma_done;
   logic [1:0] dev_idx;
   logic [3:0] dma_state;
   tri0                   d_writeM;
   tri1 [WORD_SIZE-1:0]   d_addressM;
   wire [FETCH_SIZE-1:0]  d_dataM;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dma_bus_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_addr   (cmd_addr),
      .cmd_ready  (cmd_ready),
      .BR         (BR),
      .BG         (BG),
      .dev_data   (dev_data),
      .dev_idx    (dev_idx),
      .d_writeM   (d_writeM),
      .d_addressM (d_addressM),
      .d_dataM    (d_dataM),
      .dma_state  (dma_state),
      .dma_done   (dma_done)
   );

   function automatic logic [63:0] dev_word(input int idx);
      return salt + 64'(idx) * 64'h1111_2222_3333_4445;
   endfunction

   assign dev_data = salt + 64'(dev_idx) * 64'h1111_2222_3333_4445;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // idle -> wait for grant -> own bus (slots c = 0..MEM_LAT-1 write the burst,
   // slot MEM_LAT hands over to the next burst) -> end pulse -> idle.
   typedef enum int {M_IDLE, M_WAIT, M_OWN, M_GAP, M_END} model_phase_t;
   model_phase_t   m_ph = M_IDLE;
   int             m_b = 0, m_c = 0, m_ds = 0;
   logic [15:0]    m_base = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ph <= M_IDLE; m_b <= 0; m_c <= 0; m_ds <= 0; m_base <= '0;
      end else begin
         case (m_ph)
            M_IDLE: if (cmd_valid) begin
               m_ph <= M_WAIT; m_base <= cmd_addr; m_b <= 0; m_ds <= 0;
            end
            M_WAIT: if (BG) begin m_ph <= M_OWN; m_c <= 0; end
            M_OWN: begin
               if (!BG) begin
                  m_ph <= M_WAIT; m_ds <= m_b * MEM_LAT;
               end else if (m_c < MEM_LAT) begin
                  m_ds <= (m_ds + 1 > BURST_NUM * MEM_LAT - 1) ? BURST_NUM * MEM_LAT - 1 : m_ds + 1;
                  if (m_c == MEM_LAT - 1 && m_b == BURST_NUM - 1) m_ph <= M_END;
                  else if (m_c == MEM_LAT - 1 && STEAL)           m_ph <= M_GAP;
                  else                                            m_c  <= m_c + 1;
               end else begin
                  m_b <= m_b + 1; m_c <= 0;
               end
            end
            M_GAP:  begin m_b <= m_b + 1; m_ph <= M_WAIT; end
            M_END:  m_ph <= M_IDLE;
            default: m_ph <= M_IDLE;
         endcase
      end
   end

   logic [15:0] got_addr[$];

   always @(negedge clk) begin
      logic        own;
      logic [15:0] exp_addr;
      own      = (m_ph == M_OWN) && BG;
      exp_addr = own ? m_base + 16'(m_b * WORDS_PER_BURST) : 16'hFFFF;
      check("cmd_ready", 64'(cmd_ready), 64'(m_ph == M_IDLE));
      check("BR",        64'(BR),        64'(m_ph == M_WAIT || m_ph == M_OWN));
      check("dma_done",  64'(dma_done),  64'(m_ph == M_END));
      check("dma_state", 64'(dma_state), 64'(m_ds));
      check("dev_idx",   64'(dev_idx),   64'(m_b));
      check("d_writeM",  64'(d_writeM),  64'(own && m_c == 0));
      check("d_addressM", 64'(d_addressM), 64'(exp_addr));
      if (own) check("d_dataM", d_dataM, dev_word(m_b));
      if (d_writeM === 1'b1) got_addr.push_back(d_addressM);
   end

   // ---------------- one transfer ----------------
   // lat: grant latency after BR; drop_b/drop_c: slot where BG is pulled for
   // one cycle (-1 = none); rst_b: burst during which reset is pulsed (-1 = none).
   task automatic run_xfer(input logic [15:0] base, input int lat, input int drop_b,
                           input int drop_c, input int rst_b);
      int  wait_cnt = 0, cycles = 0, br_low = 0, hit_c = -1;
      bit  drop_armed, fin = 0, br_seen = 0, rst_hit = 0;
      logic [15:0] exp_q[$];
      logic [15:0] a;
      drop_armed = (drop_b >= 0);
      got_addr.delete();
      @(posedge clk); #1;
      salt      = {$urandom, $urandom};
      cmd_addr  = base;
      cmd_valid = 1'b1;
      BG        = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      while (!fin && cycles < 300) begin
         if (rst_b >= 0 && m_ph == M_OWN && m_b == rst_b && m_c == 1) begin
            #1 reset_n = 1'b0;
            cmd_valid  = 1'b1;
            #1;
            check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
            check("rst_BR",        64'(BR),        64'd0);
            check("rst_dma_state", 64'(dma_state), 64'd0);
            check("rst_dma_done",  64'(dma_done),  64'd0);
            check("rst_dev_idx",   64'(dev_idx),   64'd0);
            check("rst_d_writeM",  64'(d_writeM),  64'd0);
            check("rst_addr_z",    64'(d_addressM), 64'hFFFF);
            @(negedge clk); #1;
            cmd_valid = 1'b0;
            BG        = 1'b0;
            reset_n   = 1'b1;
            rst_hit   = 1'b1;
            fin       = 1'b1;
         end else begin
            if (drop_armed && m_ph == M_OWN && m_b == drop_b && m_c == drop_c) begin
               BG = 1'b0; drop_armed = 1'b0; hit_c = drop_c; wait_cnt = 0;
            end else if (BR) begin
               if (wait_cnt >= lat) BG = 1'b1;
               else begin BG = 1'b0; wait_cnt++; end
            end else begin
               BG = 1'b0; wait_cnt = 0;
            end
            // a second command while busy must be ignored
            if (cycles == 3) begin cmd_valid = 1'b1; cmd_addr = base ^ 16'h5550; end
            else cmd_valid = 1'b0;
            if (BR) br_seen = 1'b1;
            else if (br_seen && !dma_done) br_low++;
            if (dma_done) fin = 1'b1;
            else begin @(posedge clk); #1; cycles++; end
         end
      end
      cmd_valid = 1'b0;
      BG        = 1'b0;
      check("xfer_finished", 64'(fin), 64'd1);
      if (!rst_hit && fin) begin
         for (int k = 0; k < BURST_NUM; k++) begin
            a = base + 16'(k * WORDS_PER_BURST);
            exp_q.push_back(a);
            if (k == drop_b && hit_c >= 1) exp_q.push_back(a);
         end
         check("write_count", 64'(got_addr.size()), 64'(exp_q.size()));
         for (int k = 0; k < exp_q.size() && k < got_addr.size(); k++)
            check("write_addr", 64'(got_addr[k]), 64'(exp_q[k]));
         check("br_low_gaps", 64'(br_low), STEAL ? 64'(BURST_NUM - 1) : 64'd0);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      run_xfer(16'h01F0, 2,  -1, -1, -1);   // basic transfer
      run_xfer(16'h0040, 20, -1, -1, -1);   // long grant latency
      run_xfer(16'h0100, 1,   1,  1, -1);   // BG drop in burst 1, second cycle
      run_xfer(16'hFFF8, 1,  -1, -1, -1);   // address wrap
      run_xfer(16'h0200, 0,  -1, -1,  2);   // reset during burst 2
      for (int i = 0; i < 12; i++) begin
         logic [15:0] rb;
         int d;
         rb = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC;
         d  = $urandom_range(0, 1);
         run_xfer(rb, $urandom_range(0, 4),
                  d ? $urandom_range(0, BURST_NUM - 1) : -1,
                  $urandom_range(0, DROP_C_MAX),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, BURST_NUM - 1) : -1);
      end
      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
